// File: rtl/simplex_pivot_ctrl.sv
// Simplex iteration sequencer: objective-row scan for the pivot column, minimum-ratio
// test through a shared divider, then (row, col) hand-off to the pivot engine.
module simplex_pivot_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NROWS      = 3,
    parameter int NCOLS      = 6,
    parameter int MAX_ITER   = 16,
    localparam int RW = $clog2(NROWS + 1),
    localparam int CW = $clog2(NCOLS + 1),
    localparam int IW = $clog2(MAX_ITER + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            status_o,
    output logic [IW-1:0]         iter_o,
    output logic                  tab_rd_en_o,
    output logic [RW-1:0]         tab_row_o,
    output logic [CW-1:0]         tab_col_o,
    input  logic [DATA_WIDTH-1:0] tab_rd_data_i,
    output logic                  div_valid_o,
    input  logic                  div_ready_i,
    output logic [DATA_WIDTH-1:0] div_num_o,
    output logic [DATA_WIDTH-1:0] div_den_o,
    input  logic                  div_res_valid_i,
    input  logic [DATA_WIDTH-1:0] div_res_i,
    output logic                  pivot_valid_o,
    input  logic                  pivot_ready_i,
    output logic [RW-1:0]         pivot_row_o,
    output logic [CW-1:0]         pivot_col_o,
    input  logic                  pivot_done_i,
    output logic [3:0]            dbg_state_o
);
    // Handshakes: a request is raised with its payload, held unchanged while ready is low,
    // and transfers in the cycle where valid and ready are both high.
    typedef enum logic [3:0] {
        IDLE, SCAN_COL, RD_COEF, RD_RHS, DIV_REQ, DIV_WAIT, PIV_REQ, PIV_WAIT, FINISH
    } state_t;

    localparam logic [1:0] ST_NONE = 2'b00, ST_OPT = 2'b01, ST_UNB = 2'b10, ST_LIM = 2'b11;

    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    function automatic logic is_neg(input logic [DATA_WIDTH-1:0] v);
        return v[31] && (v[30:0] != 31'd0) && !is_nan(v);
    endfunction

    function automatic logic is_pos(input logic [DATA_WIDTH-1:0] v);
        return !v[31] && (v[30:0] != 31'd0) && !is_nan(v);
    endfunction

    // Raw-bit sign-magnitude a < b; +0 and -0 are equal, NaN never orders.
    function automatic logic fp_lt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (is_nan(a) || is_nan(b)) return 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt, r_best_col;
    logic                  r_best_vld, r_min_vld, r_num_vld;
    logic [30:0]           r_best_mag;
    logic [RW-1:0]         r_row, r_min_row;
    logic [DATA_WIDTH-1:0] r_min, r_num, r_den;
    logic [IW-1:0]         r_iter;
    logic [1:0]            r_status;

    logic                  w_take, w_q_take, w_last_row;
    logic [1:0]            w_fin_status;
    logic [DATA_WIDTH-1:0] w_num;
    logic [IW-1:0]         w_iter_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        tab_rd_en_o   = 1'b0;
        tab_row_o     = '0;
        tab_col_o     = '0;
        div_valid_o   = 1'b0;
        div_num_o     = '0;
        div_den_o     = '0;
        pivot_valid_o = 1'b0;
        pivot_row_o   = '0;
        pivot_col_o   = '0;
        w_take        = 1'b0;
        w_q_take      = 1'b0;
        w_fin_status  = ST_NONE;
        w_last_row    = (r_row == RW'(NROWS));
        w_num         = r_num_vld ? r_num : tab_rd_data_i;
        w_iter_inc    = r_iter + 1'b1;
        case (r_state)
            IDLE: if (start_i) w_next = SCAN_COL;
            SCAN_COL: begin
                if (r_cnt < CW'(NCOLS)) begin
                    tab_rd_en_o = 1'b1;
                    tab_col_o   = r_cnt;
                end
                // Strict magnitude compare keeps the lowest column on ties.
                if (r_cnt != '0)
                    w_take = is_neg(tab_rd_data_i) &&
                             (!r_best_vld || (tab_rd_data_i[30:0] > r_best_mag));
                if (r_cnt == CW'(NCOLS)) begin
                    if (r_best_vld || w_take) begin
                        w_next = RD_COEF;
                    end else begin
                        w_next       = FINISH;
                        w_fin_status = ST_OPT;
                    end
                end
            end
            RD_COEF: begin
                tab_rd_en_o = 1'b1;
                tab_row_o   = r_row;
                tab_col_o   = r_best_col;
                w_next      = RD_RHS;
            end
            RD_RHS: begin
                if (is_pos(tab_rd_data_i)) begin
                    tab_rd_en_o = 1'b1;
                    tab_row_o   = r_row;
                    tab_col_o   = CW'(NCOLS);
                    w_next      = DIV_REQ;
                end else if (!w_last_row) begin
                    w_next = RD_COEF;
                end else if (r_min_vld) begin
                    w_next = PIV_REQ;
                end else begin
                    w_next       = FINISH;
                    w_fin_status = ST_UNB;
                end
            end
            DIV_REQ: begin
                div_valid_o = 1'b1;
                div_num_o   = w_num;
                div_den_o   = r_den;
                if (div_ready_i) w_next = DIV_WAIT;
            end
            DIV_WAIT: begin
                if (div_res_valid_i) begin
                    w_q_take = !is_nan(div_res_i) && (!r_min_vld || fp_lt(div_res_i, r_min));
                    if (!w_last_row) begin
                        w_next = RD_COEF;
                    end else if (r_min_vld || w_q_take) begin
                        w_next = PIV_REQ;
                    end else begin
                        w_next       = FINISH;
                        w_fin_status = ST_UNB;
                    end
                end
            end
            PIV_REQ: begin
                pivot_valid_o = 1'b1;
                pivot_row_o   = r_min_row;
                pivot_col_o   = r_best_col;
                if (pivot_ready_i) w_next = PIV_WAIT;
            end
            PIV_WAIT: begin
                if (pivot_done_i) begin
                    if (w_iter_inc == IW'(MAX_ITER)) begin
                        w_next       = FINISH;
                        w_fin_status = ST_LIM;
                    end else begin
                        w_next = SCAN_COL;
                    end
                end
            end
            FINISH: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_best_col <= '0;
            r_best_vld <= 1'b0;
            r_best_mag <= '0;
            r_row      <= '0;
            r_min_row  <= '0;
            r_min_vld  <= 1'b0;
            r_min      <= '0;
            r_num      <= '0;
            r_num_vld  <= 1'b0;
            r_den      <= '0;
            r_iter     <= '0;
            r_status   <= ST_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_iter     <= '0;
                        r_status   <= ST_NONE;
                        r_cnt      <= '0;
                        r_best_vld <= 1'b0;
                    end
                end
                SCAN_COL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_take) begin
                        r_best_vld <= 1'b1;
                        r_best_mag <= tab_rd_data_i[30:0];
                        r_best_col <= r_cnt - 1'b1;
                    end
                    if (r_cnt == CW'(NCOLS)) begin
                        r_row     <= RW'(1);
                        r_min_vld <= 1'b0;
                    end
                end
                RD_RHS: begin
                    r_den     <= tab_rd_data_i;
                    r_num_vld <= 1'b0;
                    if (w_next == RD_COEF) r_row <= r_row + 1'b1;
                end
                // The RHS word is only on the read bus in the first DIV_REQ cycle.
                DIV_REQ: begin
                    r_num     <= w_num;
                    r_num_vld <= 1'b1;
                end
                DIV_WAIT: begin
                    if (div_res_valid_i) begin
                        if (w_q_take) begin
                            r_min     <= div_res_i;
                            r_min_vld <= 1'b1;
                            r_min_row <= r_row;
                        end
                        if (w_next == RD_COEF) r_row <= r_row + 1'b1;
                    end
                end
                PIV_WAIT: begin
                    if (pivot_done_i) begin
                        r_iter     <= w_iter_inc;
                        r_cnt      <= '0;
                        r_best_vld <= 1'b0;
                    end
                end
                default: ;
            endcase
            if ((w_next == FINISH) && (r_state != FINISH)) r_status <= w_fin_status;
        end
    end

    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == FINISH);
    assign status_o    = r_status;
    assign iter_o      = r_iter;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_simplex_pivot_ctrl.sv
// Bench for simplex_pivot_ctrl: tableau, divider and pivot-engine models with
// expected-operation queues, run through scenario tasks.
module tb_simplex_pivot_ctrl;
    localparam int NR = 3, NC = 6, MI = 16;
    localparam logic [31:0] F_0 = 32'h0000_0000, F_1 = 32'h3F80_0000, F_2 = 32'h4000_0000;
    localparam logic [31:0] F_3 = 32'h4040_0000, F_4 = 32'h4080_0000, F_8 = 32'h4100_0000;
    localparam logic [31:0] F_12 = 32'h4140_0000, F_M1 = 32'hBF80_0000, F_M2 = 32'hC000_0000;
    localparam logic [31:0] F_M3 = 32'hC040_0000, F_M5 = 32'hC0A0_0000, F_MZ = 32'h8000_0000;
    localparam logic [31:0] F_NANN = 32'hFFC0_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, start_i = 1'b0;
    logic        busy_o, done_o, tab_rd_en_o, div_valid_o, pivot_valid_o;
    logic [1:0]  status_o;
    logic [4:0]  iter_o;
    logic [1:0]  tab_row_o, pivot_row_o;
    logic [2:0]  tab_col_o, pivot_col_o;
    logic [31:0] tab_rd_data_i = 32'd0, div_num_o, div_den_o, div_res_i = 32'd0;
    logic        div_ready_i = 1'b0, div_res_valid_i = 1'b0;
    logic        pivot_ready_i = 1'b0, pivot_done_i = 1'b0;
    logic [3:0]  dbg_state_o;

    always #5 clk = ~clk;

    simplex_pivot_ctrl #(.DATA_WIDTH(32), .NROWS(NR), .NCOLS(NC), .MAX_ITER(MI)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .status_o(status_o), .iter_o(iter_o), .tab_rd_en_o(tab_rd_en_o), .tab_row_o(tab_row_o),
        .tab_col_o(tab_col_o), .tab_rd_data_i(tab_rd_data_i), .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i), .div_num_o(div_num_o), .div_den_o(div_den_o),
        .div_res_valid_i(div_res_valid_i), .div_res_i(div_res_i), .pivot_valid_o(pivot_valid_o),
        .pivot_ready_i(pivot_ready_i), .pivot_row_o(pivot_row_o), .pivot_col_o(pivot_col_o),
        .pivot_done_i(pivot_done_i), .dbg_state_o(dbg_state_o)
    );

    logic [31:0] tab [0:NR][0:NC];
    logic [4:0]  exp_q[$];      // expected pivots {row, col}
    logic [63:0] div_exp_q[$];  // expected divides {num, den}
    int n_checks = 0, n_pass = 0;
    int n_div_xfer = 0, n_piv_xfer = 0, n_div_stall_chk = 0, n_piv_stall_chk = 0;
    int div_stall_cfg = 0, piv_stall_cfg = 0, div_lat = 1;
    int div_left = 0, div_stall_left = 0, piv_left = 0, piv_stall_left = 0;
    bit flip_on_done = 1'b0, div_wait_prev = 1'b0, piv_wait_prev = 1'b0, was_wait;
    logic [31:0] prev_num, prev_den, div_q;
    logic [4:0]  prev_piv, got_piv;
    logic [63:0] exp_div;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    // Tableau read port: data is valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (tab_rd_en_o) tab_rd_data_i <= tab[tab_row_o][tab_col_o];
        else             tab_rd_data_i <= $urandom;
    end

    // Divider model with programmable ready stall and result latency.
    always @(negedge clk) begin
        div_res_valid_i = 1'b0;
        if (div_left > 0) begin
            div_left--;
            if (div_left == 0) begin
                div_res_valid_i = 1'b1;
                div_res_i = div_q;
            end
        end
        was_wait = div_wait_prev;
        div_wait_prev = 1'b0;
        if (was_wait) begin
            n_checks++; n_div_stall_chk++;
            if (div_valid_o !== 1'b1 || div_num_o !== prev_num || div_den_o !== prev_den)
                $display("FAIL div_hold: valid=%b num=%h den=%h, required valid=1 num=%h den=%h",
                         div_valid_o, div_num_o, div_den_o, prev_num, prev_den);
            else n_pass++;
        end
        if (div_valid_o === 1'b1 && rst_i === 1'b0) begin
            if (!was_wait) div_stall_left = div_stall_cfg;
            div_ready_i = (div_stall_left == 0);
            if (div_stall_left > 0) div_stall_left--;
            if (div_ready_i) begin
                n_div_xfer++;
                n_checks++;
                if (div_exp_q.size() == 0) begin
                    $display("FAIL div_op: unexpected request num=%h den=%h", div_num_o, div_den_o);
                end else begin
                    exp_div = div_exp_q.pop_front();
                    if ({div_num_o, div_den_o} !== exp_div)
                        $display("FAIL div_op: got %h/%h, required %h/%h",
                                 div_num_o, div_den_o, exp_div[63:32], exp_div[31:0]);
                    else n_pass++;
                end
                div_q = r2f(f2r(div_num_o) / f2r(div_den_o));
                div_left = div_lat;
            end else begin
                div_wait_prev = 1'b1;
                prev_num = div_num_o;
                prev_den = div_den_o;
            end
        end else begin
            div_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Pivot-engine model: scoreboard pop on transfer, done pulse two cycles later.
    always @(negedge clk) begin
        pivot_done_i = 1'b0;
        if (piv_left > 0) begin
            piv_left--;
            if (piv_left == 0) begin
                pivot_done_i = 1'b1;
                if (flip_on_done) for (int c = 0; c <= NC; c++) tab[0][c] = F_0;
            end
        end
        if (piv_wait_prev) begin
            n_checks++; n_piv_stall_chk++;
            if (pivot_valid_o !== 1'b1 || {pivot_row_o, pivot_col_o} !== prev_piv)
                $display("FAIL piv_hold: valid=%b rc=%h, required valid=1 rc=%h",
                         pivot_valid_o, {pivot_row_o, pivot_col_o}, prev_piv);
            else n_pass++;
        end
        was_wait = piv_wait_prev;
        piv_wait_prev = 1'b0;
        if (pivot_valid_o === 1'b1 && rst_i === 1'b0) begin
            if (!was_wait) piv_stall_left = piv_stall_cfg;
            pivot_ready_i = (piv_stall_left == 0);
            if (piv_stall_left > 0) piv_stall_left--;
            if (pivot_ready_i) begin
                n_piv_xfer++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pivot_op: unexpected pivot rc=%h", {pivot_row_o, pivot_col_o});
                end else begin
                    got_piv = exp_q.pop_front();
                    if ({pivot_row_o, pivot_col_o} !== got_piv)
                        $display("FAIL pivot_op: got row %0d col %0d, required row %0d col %0d",
                                 pivot_row_o, pivot_col_o, got_piv[4:3], got_piv[2:0]);
                    else n_pass++;
                end
                piv_left = 2;
            end else begin
                piv_wait_prev = 1'b1;
                prev_piv = {pivot_row_o, pivot_col_o};
            end
        end else begin
            pivot_ready_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_tab();
        for (int r = 0; r <= NR; r++)
            for (int c = 0; c <= NC; c++) tab[r][c] = F_0;
    endtask

    task automatic load_basic();
        clear_tab();
        tab[0][0] = F_M3; tab[0][1] = F_M5;
        tab[1][0] = F_1;  tab[1][1] = F_2; tab[1][2] = F_1; tab[1][NC] = F_8;
        tab[2][0] = F_3;  tab[2][1] = F_2; tab[2][3] = F_1; tab[2][NC] = F_12;
        flip_on_done = 1'b1;
        exp_q.push_back({2'd1, 3'd1});
        div_exp_q.push_back({F_8, F_2});
        div_exp_q.push_back({F_12, F_2});
    endtask

    task automatic run_check(input string name, input logic [1:0] es, input int ei,
                             input int ed, input int ep, input bit poke, input bit start_on_done);
        int cyc;
        bit seen;
        n_div_xfer = 0; n_piv_xfer = 0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL %s_start: busy=%b, required 1", name, busy_o);
        else n_pass++;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk); cyc++;
            start_i = (poke && cyc == 4);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                start_i = start_on_done;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL %s_timeout: no done_o in %0d cycles", name, cyc);
        else n_pass++;
        n_checks++;
        if (status_o !== es || iter_o !== 5'(ei))
            $display("FAIL %s_result: status=%b iter=%0d, required status=%b iter=%0d",
                     name, status_o, iter_o, es, ei);
        else n_pass++;
        @(negedge clk); start_i = 1'b0;
        n_checks++;
        if ({done_o, busy_o} !== 2'b00)
            $display("FAIL %s_done_pulse: done=%b busy=%b, required 0 0", name, done_o, busy_o);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || status_o !== es || iter_o !== 5'(ei))
            $display("FAIL %s_hold: busy=%b status=%b iter=%0d, required 0 %b %0d",
                     name, busy_o, status_o, iter_o, es, ei);
        else n_pass++;
        n_checks++;
        if (n_div_xfer != ed || n_piv_xfer != ep)
            $display("FAIL %s_counts: divides=%0d pivots=%0d, required %0d %0d",
                     name, n_div_xfer, n_piv_xfer, ed, ep);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || div_exp_q.size() != 0)
            $display("FAIL %s_queues: pivots left=%0d divides left=%0d, required 0 0",
                     name, exp_q.size(), div_exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_o, done_o, tab_rd_en_o, div_valid_o, pivot_valid_o} !== 5'b0 ||
            status_o !== 2'b00 || iter_o !== 5'd0 || dbg_state_o !== 4'd0 ||
            {tab_row_o, tab_col_o, pivot_row_o, pivot_col_o} !== 10'd0)
            $display("FAIL reset_values: busy=%b done=%b status=%b iter=%0d state=%0d",
                     busy_o, done_o, status_o, iter_o, dbg_state_o);
        else n_pass++;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_idle: busy=%b, required 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_basic();
        load_basic();
        run_check("basic", 2'b01, 1, 2, 1, 1'b1, 1'b1);
    endtask

    task automatic test_tie();
        clear_tab();
        tab[0][0] = F_M2; tab[0][1] = F_M2;
        tab[1][0] = F_4; tab[1][NC] = F_8;
        tab[2][0] = F_2; tab[2][NC] = F_4;
        flip_on_done = 1'b1;
        exp_q.push_back({2'd1, 3'd0});
        div_exp_q.push_back({F_8, F_4});
        div_exp_q.push_back({F_4, F_2});
        run_check("tie", 2'b01, 1, 2, 1, 1'b0, 1'b0);
    endtask

    task automatic test_unbounded();
        clear_tab();
        tab[0][0] = F_MZ; tab[0][1] = F_NANN; tab[0][2] = F_M1; tab[0][3] = F_M1;
        tab[1][2] = F_0; tab[2][2] = F_M3; tab[3][2] = F_MZ;
        tab[1][3] = F_1; tab[1][NC] = F_4;
        flip_on_done = 1'b0;
        run_check("unbounded", 2'b10, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic load_limit(input int npiv, input int ndiv);
        clear_tab();
        tab[0][0] = F_M1; tab[1][0] = F_1; tab[1][NC] = F_1;
        flip_on_done = 1'b0;
        for (int i = 0; i < npiv; i++) exp_q.push_back({2'd1, 3'd0});
        for (int i = 0; i < ndiv; i++) div_exp_q.push_back({F_1, F_1});
    endtask

    task automatic test_iter_limit();
        load_limit(MI, MI);
        run_check("iter_limit", 2'b11, MI, MI, MI, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        div_stall_cfg = 5; piv_stall_cfg = 3;
        n_div_stall_chk = 0; n_piv_stall_chk = 0;
        load_basic();
        run_check("stall", 2'b01, 1, 2, 1, 1'b0, 1'b0);
        n_checks++;
        if (n_div_stall_chk != 10 || n_piv_stall_chk != 3)
            $display("FAIL stall_cycles: div held %0d piv held %0d, required 10 3",
                     n_div_stall_chk, n_piv_stall_chk);
        else n_pass++;
        div_stall_cfg = 0; piv_stall_cfg = 0;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit bad;
        div_lat = 8;
        load_limit(3, 4);
        n_div_xfer = 0; n_piv_xfer = 0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        cyc = 0;
        while (n_div_xfer < 4 && cyc < 2000) begin
            @(negedge clk); cyc++;
        end
        n_checks++;
        if (n_div_xfer < 4) $display("FAIL midrst_reach: divides=%0d, required 4", n_div_xfer);
        else n_pass++;
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        n_checks++;
        if ({busy_o, done_o, tab_rd_en_o, div_valid_o, pivot_valid_o} !== 5'b0 ||
            status_o !== 2'b00 || iter_o !== 5'd0 ||
            {tab_row_o, tab_col_o, pivot_row_o, pivot_col_o} !== 10'd0)
            $display("FAIL midrst_values: busy=%b status=%b iter=%0d, required 0 00 0",
                     busy_o, status_o, iter_o);
        else n_pass++;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy_o !== 1'b0 || pivot_valid_o !== 1'b0 || div_valid_o !== 1'b0 ||
                tab_rd_en_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad || n_piv_xfer != 3)
            $display("FAIL midrst_quiet: activity=%b pivots=%0d, required 0 3", bad, n_piv_xfer);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0 || div_exp_q.size() != 0)
            $display("FAIL midrst_queues: pivots left=%0d divides left=%0d, required 0 0",
                     exp_q.size(), div_exp_q.size());
        else n_pass++;
        div_lat = 1;
        load_basic();
        run_check("after_reset", 2'b01, 1, 2, 1, 1'b0, 1'b0);
    endtask

    initial begin
        clear_tab();
        test_reset();
        test_basic();
        test_tie();
        test_unbounded();
        test_iter_limit();
        test_stall();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/simplex_pivot_ctrl.md
Name: simplex_pivot_ctrl

Overview:
- Sequences simplex iterations over the tableau held in the simplex datapath.
- Each iteration: choose the pivot column (most negative objective entry), run the minimum-ratio test for the pivot row, then hand (row, col) to the pivot engine.
- Repeats until optimal, unbounded or iteration limit.
- Talks to three blocks: tableau read port (1-cycle latency), shared IEEE-754 single divider (valid/ready), pivot engine (valid/ready + done pulse).

Parameters:
- DATA_WIDTH, 32, IEEE-754 word width (only 32 supported).
- NROWS, 3, constraint rows; row 0 is objective, rows 1..NROWS are constraints.
- NCOLS, 6, coefficient columns 0..NCOLS-1; column NCOLS is RHS.
- MAX_ITER, 16, pivot limit per run.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start run (ignored while busy_o=1)
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at end of run
- status_o  out  2  result: 00 none, 01 optimal, 10 unbounded, 11 iteration limit
- iter_o  out  $clog2(MAX_ITER+1)  pivots completed in current/last run
- tab_rd_en_o  out  1  tableau read strobe
- tab_row_o  out  $clog2(NROWS+1)  read row
- tab_col_o  out  $clog2(NCOLS+1)  read column
- tab_rd_data_i  in  DATA_WIDTH  read data, valid the cycle after tab_rd_en_o
- div_valid_o  out  1  divide request
- div_ready_i  in  1  divider accepts
- div_num_o  out  DATA_WIDTH  numerator (RHS)
- div_den_o  out  DATA_WIDTH  denominator (pivot-column coefficient)
- div_res_valid_i  in  1  quotient valid (single-cycle)
- div_res_i  in  DATA_WIDTH  quotient
- pivot_valid_o  out  1  pivot request
- pivot_ready_i  in  1  pivot engine accepts
- pivot_row_o  out  $clog2(NROWS+1)  pivot row
- pivot_col_o  out  $clog2(NCOLS+1)  pivot column
- pivot_done_i  in  1  one-cycle pulse: tableau update complete

Behaviour:
- Reset (any cycle, including mid-run):
  - Next cycle: IDLE; busy_o, done_o, tab_rd_en_o, div_valid_o, pivot_valid_o = 0; status_o = 00; iter_o = 0; row/col outputs = 0.
  - Late div_res_valid_i or pivot_done_i arriving after reset is ignored.
- FSM states: IDLE, SCAN_COL, RD_COEF, RD_RHS, DIV_REQ, DIV_WAIT, PIV_REQ, PIV_WAIT, FINISH.
- IDLE:
  - start_i=1 → SCAN_COL; busy_o=1, iter_o=0, status_o=00.
- SCAN_COL:
  - Read row 0, cols 0..NCOLS-1, one per cycle, pipelined (NCOLS+1 cycles).
  - Candidate requires sign=1, nonzero magnitude, not NaN; -0.0 is not negative.
  - Most negative wins (largest magnitude); ties keep the lowest column.
  - No candidate → FINISH, status 01.
- FP compare:
  - Sign-magnitude on raw bits, no rounding.
  - NaN is never negative, never positive, never smaller.
- Ratio test, for r = 1..NROWS:
  - RD_COEF: read a[r][pc]. If a is not strictly positive (sign=0, nonzero, not NaN), skip to next r.
  - RD_RHS: read b[r] from column NCOLS.
  - DIV_REQ: hold div_valid_o with stable num/den until div_ready_i.
  - DIV_WAIT: wait for div_res_valid_i.
  - Quotient strictly less than current min (or first valid) → record row; ties keep the lower row.
  - No positive coefficient in column → FINISH, status 10.
- PIV_REQ:
  - pivot_valid_o=1 with row/col held stable until pivot_ready_i; transfer happens in the cycle both are 1.
- PIV_WAIT:
  - On pivot_done_i, iter_o += 1.
  - If iter_o then equals MAX_ITER → FINISH, status 11; else → SCAN_COL.
  - pivot_done_i in any other state is ignored.
- FINISH:
  - done_o=1 for one cycle; busy_o=0 from the next cycle.
  - status_o and iter_o hold until next start_i or reset.
- Simultaneous start_i with done_o: start_i ignored; a new run needs start_i while in IDLE.
- Read port: at most one read per cycle. No read is issued while waiting on the divider or pivot engine.

Test Plan:
- Tableau row0 = [-3,-5,0,0,0,0 | 0], row1 = [1,2,1,0,0,0 | 8], row2 = [3,2,0,1,0,0 | 12], row3 all 0; model flips row0 to nonnegative after first pivot_done → pivot (row1,col1) issued (ratios 4 < 6), one pivot, status 01, iter_o 1, one done_o pulse.
- Row0 = [-2,-2,0,0,0,0 | 0] → tie resolves to col 0; rows with col0 coefs 4 and 2, RHS 8 and 4 (ratio tie 2.0) → pivot row 1.
- Row0 col2 = -1.0, col2 coefficients {0, -3, -0.0} → no divide requests, status 10, iter_o 0.
- Objective never becomes nonnegative → exactly MAX_ITER=16 pivots, then status 11, iter_o 16.
- div_ready_i low 5 cycles and pivot_ready_i low 3 cycles → div_valid_o/pivot_valid_o and operands stay stable throughout, single transfer each.
- Assert rst_i during DIV_WAIT, then pulse div_res_valid_i → all outputs at reset values, no pivot request; subsequent start_i runs normally. Also: start_i while busy → no effect.
